mig_op_sequencer: RTL

- Upstream feeder for maj_state_machine_3x8_decoder.
- Accepts majority-op commands (5-bit op + start address) from the host, buffers them in a small FIFO, and issues them one at a time to the decoder.
- Drives the decoder's MAJ_OP_REG, address_start and enable; waits for the decoder's execute_MIG completion pulse; recovers via a watchdog timeout.

---
 rtl/mig_pkg.sv | 16 +
 rtl/mig_cmd_fifo.sv | 54 +++++
 rtl/mig_op_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mig_pkg.sv
// Shared definitions for the majority-op sequencer: state encoding,
// default field widths and the MAJ_OP_REG op-field position.
package mig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int OP_W_DEF   = 5;
    localparam int ADDR_W_DEF = 5;
    localparam int OP_MSB     = 31;

endpackage

// File: rtl/mig_cmd_fifo.sv
// Synchronous command FIFO; push while full is dropped, flush empties it.
module mig_cmd_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mig_op_sequencer.sv
// Queues majority-op commands and issues them one at a time to the
// 3x8 decoder, waiting for execute_mig or a watchdog timeout.
module mig_op_sequencer
    import mig_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [OP_W-1:0]          wr_op,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     start,
    input  logic                     abort,
    output logic [31:0]              maj_op_reg,
    output logic [ADDR_W-1:0]        address_start,
    output logic                     enable,
    input  logic                     execute_mig,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     done,
    output logic                     timeout_err
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                  state;
    logic [TW-1:0]           timer;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [OP_W+ADDR_W-1:0]  head;
    logic [OP_W-1:0]         head_op;
    logic [ADDR_W-1:0]       head_addr;
    logic [31:0]             op_word;

    assign wr_ready  = !full;
    assign push      = wr_valid && wr_ready && !abort;
    assign pop       = (state == ISSUE) && !abort;
    assign head_op   = head[ADDR_W +: OP_W];
    assign head_addr = head[ADDR_W-1:0];

    always_comb begin
        op_word = '0;
        op_word[OP_MSB -: OP_W] = head_op;
    end

    mig_cmd_fifo #(
        .W     (OP_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .wdata ({wr_op, wr_addr}),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            maj_op_reg    <= '0;
            address_start <= '0;
            enable        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                enable <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !empty) begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        maj_op_reg    <= op_word;
                        address_start <= head_addr;
                        enable        <= 1'b1;
                        timer         <= '0;
                        state         <= WAIT;
                    end
                    WAIT: begin
                        if (execute_mig) begin
                            enable <= 1'b0;
                            state  <= GAP;
                        end else if (timer == TW'(TIMEOUT - 1)) begin
                            enable      <= 1'b0;
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    GAP: begin
                        // A push landing this cycle counts as queued work.
                        if (!empty || push) begin
                            state <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
